// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU issue block.
// Holds the 4-bit ALU ctrl codes, the operand-select encodings used between
// the decoder and the pipeline, and the RV32I opcode/funct3 constants.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'd0,
    ALU_OR      = 4'd1,
    ALU_ADD     = 4'd2,
    ALU_SUB     = 4'd3,
    ALU_XOR     = 4'd4,
    ALU_EQ      = 4'd5,
    ALU_NE      = 4'd6,
    ALU_LTU     = 4'd7,
    ALU_GEU     = 4'd8,
    ALU_LT      = 4'd9,
    ALU_GE      = 4'd10,
    ALU_ILLEGAL = 4'd15
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    OP1_RS1,
    OP1_PC,
    OP1_ZERO
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_RS2,
    OP2_IMM,
    OP2_FOUR,
    OP2_ZERO
  } op2_sel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // OP / OP-IMM funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // BRANCH funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational RV32I decode for the ALU issue stage.
// Ports: opcode/funct3/funct7b5 in; ctrl code, operand selects,
// is_branch and illegal out. Illegal ops get ctrl=ALU_ILLEGAL with both
// operands forced to zero.
module alu_issue_dec
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output alu_ctrl_e  ctrl,
  output op1_sel_e   op1_sel,
  output op2_sel_e   op2_sel,
  output logic       is_branch,
  output logic       illegal
);

  logic      bad;
  alu_ctrl_e arith_ctrl;

  // funct3 map shared by OP and OP-IMM; the SUB variant is applied below.
  always_comb begin
    arith_ctrl = ALU_ADD;
    case (funct3)
      F3_ADD:  arith_ctrl = ALU_ADD;
      F3_SLT:  arith_ctrl = ALU_LT;
      F3_SLTU: arith_ctrl = ALU_LTU;
      F3_XOR:  arith_ctrl = ALU_XOR;
      F3_OR:   arith_ctrl = ALU_OR;
      F3_AND:  arith_ctrl = ALU_AND;
      default: arith_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    ctrl      = ALU_ADD;
    op1_sel   = OP1_RS1;
    op2_sel   = OP2_RS2;
    is_branch = 1'b0;
    bad       = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl = arith_ctrl;
        if (funct3 == F3_ADD && funct7b5) ctrl = ALU_SUB;
        if (funct3 == F3_SLL || funct3 == F3_SR) bad = 1'b1;
      end
      OPC_OP_IMM: begin
        op2_sel = OP2_IMM;
        ctrl    = arith_ctrl;
        if (funct3 == F3_SLL || funct3 == F3_SR) bad = 1'b1;
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        case (funct3)
          F3_BEQ:  ctrl = ALU_EQ;
          F3_BNE:  ctrl = ALU_NE;
          F3_BLT:  ctrl = ALU_LT;
          F3_BGE:  ctrl = ALU_GE;
          F3_BLTU: ctrl = ALU_LTU;
          F3_BGEU: ctrl = ALU_GEU;
          default: bad  = 1'b1;
        endcase
      end
      OPC_LUI: begin
        op1_sel = OP1_ZERO;
        op2_sel = OP2_IMM;
      end
      OPC_AUIPC: begin
        op1_sel = OP1_PC;
        op2_sel = OP2_IMM;
      end
      OPC_LOAD, OPC_STORE: op2_sel = OP2_IMM;
      OPC_JAL, OPC_JALR: begin
        op1_sel = OP1_PC;
        op2_sel = OP2_FOUR;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ctrl      = ALU_ILLEGAL;
      op1_sel   = OP1_ZERO;
      op2_sel   = OP2_ZERO;
      is_branch = 1'b0;
    end
  end

  assign illegal = bad;

endmodule

// File: rtl/alu_issue.sv
// Issue/collect end of the execute-stage ALU interface.
// Stage A registers decoded operands and ctrl that drive the external
// combinational ALU; stage B captures alu_out with tag and flags.
// Ports: clk, rstn (async active-low), flush; in_* valid/ready handshake
// with RV32I fields; alu_data1/alu_data2/alu_ctrl to the ALU, alu_out back;
// out_* valid/ready handshake with result, branch/taken, illegal and tag.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic [XLEN-1:0]  alu_data1,
  output logic [XLEN-1:0]  alu_data2,
  output logic [3:0]       alu_ctrl,
  input  logic [XLEN-1:0]  alu_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_is_branch,
  output logic             out_taken,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  alu_ctrl_e dec_ctrl;
  op1_sel_e  dec_op1_sel;
  op2_sel_e  dec_op2_sel;
  logic      dec_is_branch;
  logic      dec_illegal;

  alu_issue_dec u_dec (
    .opcode    (in_opcode),
    .funct3    (in_funct3),
    .funct7b5  (in_funct7b5),
    .ctrl      (dec_ctrl),
    .op1_sel   (dec_op1_sel),
    .op2_sel   (dec_op2_sel),
    .is_branch (dec_is_branch),
    .illegal   (dec_illegal)
  );

  logic [XLEN-1:0] op1, op2;

  always_comb begin
    case (dec_op1_sel)
      OP1_RS1: op1 = in_rs1;
      OP1_PC:  op1 = in_pc;
      default: op1 = '0;
    endcase
    case (dec_op2_sel)
      OP2_RS2:  op2 = in_rs2;
      OP2_IMM:  op2 = in_imm;
      OP2_FOUR: op2 = XLEN'(4);
      default:  op2 = '0;
    endcase
  end

  logic             a_valid_q, a_valid_d;
  logic [XLEN-1:0]  a_data1_q, a_data1_d;
  logic [XLEN-1:0]  a_data2_q, a_data2_d;
  logic [3:0]       a_ctrl_q, a_ctrl_d;
  logic [TAG_W-1:0] a_tag_q, a_tag_d;
  logic             a_branch_q, a_branch_d;
  logic             a_illegal_q, a_illegal_d;

  logic             b_valid_q, b_valid_d;
  logic [XLEN-1:0]  b_result_q, b_result_d;
  logic [TAG_W-1:0] b_tag_q, b_tag_d;
  logic             b_branch_q, b_branch_d;
  logic             b_illegal_q, b_illegal_d;

  logic a_adv;

  assign a_adv    = !b_valid_q || out_ready;
  assign in_ready = !a_valid_q || a_adv;

  always_comb begin
    a_valid_d   = a_valid_q;
    a_data1_d   = a_data1_q;
    a_data2_d   = a_data2_q;
    a_ctrl_d    = a_ctrl_q;
    a_tag_d     = a_tag_q;
    a_branch_d  = a_branch_q;
    a_illegal_d = a_illegal_q;
    if (flush) begin
      a_valid_d = 1'b0;
    end else if (in_ready) begin
      a_valid_d = in_valid;
      if (in_valid) begin
        a_data1_d   = op1;
        a_data2_d   = op2;
        a_ctrl_d    = dec_ctrl;
        a_tag_d     = in_tag;
        a_branch_d  = dec_is_branch;
        a_illegal_d = dec_illegal;
      end
    end
  end

  // When A advances empty, b_valid falls: that is how B drains.
  always_comb begin
    b_valid_d   = b_valid_q;
    b_result_d  = b_result_q;
    b_tag_d     = b_tag_q;
    b_branch_d  = b_branch_q;
    b_illegal_d = b_illegal_q;
    if (flush) begin
      b_valid_d = 1'b0;
    end else if (a_adv) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        // illegal ops report zero regardless of what the ALU returns
        b_result_d  = a_illegal_q ? '0 : alu_out;
        b_tag_d     = a_tag_q;
        b_branch_d  = a_branch_q;
        b_illegal_d = a_illegal_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_valid_q   <= 1'b0;
      a_data1_q   <= '0;
      a_data2_q   <= '0;
      a_ctrl_q    <= '0;
      a_tag_q     <= '0;
      a_branch_q  <= 1'b0;
      a_illegal_q <= 1'b0;
      b_valid_q   <= 1'b0;
      b_result_q  <= '0;
      b_tag_q     <= '0;
      b_branch_q  <= 1'b0;
      b_illegal_q <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_data1_q   <= a_data1_d;
      a_data2_q   <= a_data2_d;
      a_ctrl_q    <= a_ctrl_d;
      a_tag_q     <= a_tag_d;
      a_branch_q  <= a_branch_d;
      a_illegal_q <= a_illegal_d;
      b_valid_q   <= b_valid_d;
      b_result_q  <= b_result_d;
      b_tag_q     <= b_tag_d;
      b_branch_q  <= b_branch_d;
      b_illegal_q <= b_illegal_d;
    end
  end

  assign alu_data1     = a_data1_q;
  assign alu_data2     = a_data2_q;
  assign alu_ctrl      = a_ctrl_q;
  assign out_valid     = b_valid_q;
  assign out_result    = b_result_q;
  assign out_tag       = b_tag_q;
  assign out_is_branch = b_branch_q;
  assign out_illegal   = b_illegal_q;
  assign out_taken     = b_branch_q && b_result_q[0];

endmodule
